fifo_put_arbiter: RTL and testbench

//  Write-side arbiter for the async FIFO. Shares the FIFO's single put/data_in port among NUM_REQ requesters in the wclk domain.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_rr_pick.sv | 30 +++
 rtl/fifo_put_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_put_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the async FIFO write-side arbiter:
// FSM state encoding and a constant-width helper.
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Ceiling log2, iterative; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: first set request strictly after i_rr_ptr, wrapping,
// so the requester at i_rr_ptr itself comes last.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);

    int w_cand;

    always_comb begin
        o_any  = |i_req;
        o_idx  = '0;
        w_cand = 0;
        // Walk from farthest to nearest so the nearest hit is the last write.
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            w_cand = (int'(i_rr_ptr) + k) % int'(NUM_REQ);
            if (i_req[IDX_W'(w_cand)]) begin
                o_idx = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/fifo_put_arbiter.sv
// Write-side arbiter for the async FIFO: round-robin, bounded-burst sharing of
// the single put/data_in port among NUM_REQ requesters, with full_bar back-pressure.
module fifo_put_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned IDX_W     = clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          full_bar,
    output logic                          put,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_id,
    output logic [CNT_WIDTH-1:0]          put_count
);

    localparam int unsigned BEAT_W = clog2(MAX_BURST) + 1;

    logic [0:0]           r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_owner, w_owner_nxt;
    logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [BEAT_W-1:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_put_count, w_put_count_nxt;

    logic                 w_burst;
    logic                 w_owner_req;
    logic                 w_put;
    logic                 w_last_beat;
    logic                 w_release;
    logic                 w_any;
    logic [IDX_W-1:0]     w_pick_ptr;
    logic [IDX_W-1:0]     w_pick_idx;

    assign w_burst     = (r_state == ST_BURST);
    assign w_owner_req = req[r_owner];
    assign w_put       = w_burst & w_owner_req & full_bar;
    assign w_last_beat = (r_beat_cnt == BEAT_W'(MAX_BURST - 1));
    assign w_release   = w_burst & (~w_owner_req | (w_put & w_last_beat));

    // On release the current owner becomes the pointer, so it is served last.
    assign w_pick_ptr  = w_burst ? r_owner : r_rr_ptr;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_rr_ptr (w_pick_ptr),
        .o_any    (w_any),
        .o_idx    (w_pick_idx)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_put_count_nxt = w_put ? r_put_count + CNT_WIDTH'(1) : r_put_count;

        if (!w_burst) begin
            if (w_any) begin
                w_state_nxt    = ST_BURST;
                w_owner_nxt    = w_pick_idx;
                w_beat_cnt_nxt = '0;
            end
        end else if (w_release) begin
            w_rr_ptr_nxt = r_owner;
            if (w_any) begin
                w_owner_nxt    = w_pick_idx;
                w_beat_cnt_nxt = '0;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else if (w_put) begin
            w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
        end
    end

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt  <= '0;
            r_put_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_put_count <= w_put_count_nxt;
        end
    end

    always_comb begin
        data_in = req_data[0 +: DATA_WIDTH];
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_owner == IDX_W'(i)) begin
                data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign put         = w_put;
    assign ack         = {NUM_REQ{w_put}} & (NUM_REQ'(1) << r_owner);
    assign grant_valid = w_burst;
    assign grant_id    = r_owner;
    assign put_count   = r_put_count;

endmodule

// File: tb/tb_fifo_put_arbiter.sv
// Directed bench for fifo_put_arbiter: table of per-cycle vectors plus
// hand sequences for async reset and single-beat round-robin rotation.
module tb_fifo_put_arbiter;

    logic        wclk;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full_bar;

    logic [3:0]  ack;
    logic        put;
    logic [7:0]  data_in;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] put_count;

    logic [3:0]  ack1;
    logic        put1;
    logic [7:0]  data_in1;
    logic        grant_valid1;
    logic [1:0]  grant_id1;
    logic [1:0]  put_count1;

    int n_total = 0;
    int n_pass  = 0;
    int n_word[4];

    fifo_put_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4),
        .CNT_WIDTH  (16)
    ) dut (
        .wclk        (wclk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .full_bar    (full_bar),
        .put         (put),
        .data_in     (data_in),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .put_count   (put_count)
    );

    // Single-beat bursts and a 2-bit counter to expose rotation and wrap.
    fifo_put_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (1),
        .CNT_WIDTH  (2)
    ) dut1 (
        .wclk        (wclk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack1),
        .full_bar    (full_bar),
        .put         (put1),
        .data_in     (data_in1),
        .grant_valid (grant_valid1),
        .grant_id    (grant_id1),
        .put_count   (put_count1)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0]  req;
        logic        fb;
        logic        put;
        logic [3:0]  ack;
        logic [7:0]  data;
        logic        gv;
        logic [1:0]  gid;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    // Word k of requester i: requester index in the top two bits.
    function automatic logic [7:0] wd(input int i, input int k);
        return 8'(((i & 3) << 6) | (k & 63));
    endfunction

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = wd(i, n_word[i]);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [3:0] r, input logic f, input logic p, input logic [3:0] a,
                       input logic [7:0] d, input logic g, input logic [1:0] id,
                       input logic [15:0] c);
        vec_t v;
        v.req = r; v.fb = f; v.put = p; v.ack = a; v.data = d; v.gv = g; v.gid = id; v.cnt = c;
        vq.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Single requester: burst of 4 then seamless re-grant to itself.
        add(4'b0001, 1, 0, 4'b0000, 8'h00, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(4'b0001, 1, 1, 4'b0001, wd(0, k), 1, 0, 16'(k));
        // req 0 and 2: alternate bursts of 4 with no idle cycles.
        for (int k = 5; k < 8; k++)  add(4'b0101, 1, 1, 4'b0001, wd(0, k), 1, 0, 16'(k));
        for (int k = 0; k < 4; k++)  add(4'b0101, 1, 1, 4'b0100, wd(2, k), 1, 2, 16'(8 + k));
        for (int k = 8; k < 12; k++) add(4'b0101, 1, 1, 4'b0001, wd(0, k), 1, 0, 16'(4 + k));
        // Stall for 3 cycles after beat 2 of a burst.
        add(4'b0101, 1, 1, 4'b0100, wd(2, 4), 1, 2, 16);
        add(4'b0101, 1, 1, 4'b0100, wd(2, 5), 1, 2, 17);
        for (int k = 0; k < 3; k++) add(4'b0101, 0, 0, 4'b0000, 8'h00, 1, 2, 18);
        add(4'b0101, 1, 1, 4'b0100, wd(2, 6), 1, 2, 18);
        add(4'b0101, 1, 1, 4'b0100, wd(2, 7), 1, 2, 19);
        // Owner 0 withdraws after one beat while req 3 waits.
        add(4'b1001, 1, 1, 4'b0001, wd(0, 12), 1, 0, 20);
        add(4'b1000, 1, 0, 4'b0000, 8'h00, 1, 0, 21);
        add(4'b1000, 1, 1, 4'b1000, wd(3, 0), 1, 3, 21);
        add(4'b0000, 1, 0, 4'b0000, 8'h00, 1, 3, 22);
        add(4'b0000, 1, 0, 4'b0000, 8'h00, 0, 3, 22);

        for (int i = 0; i < 4; i++) n_word[i] = 0;
        reset_n  = 1'b0;
        req      = 4'b1111;
        full_bar = 1'b1;
        drive_data();
        #2;
        check("reset put", 32'(put), 0);
        check("reset ack", 32'(ack), 0);
        check("reset grant_valid", 32'(grant_valid), 0);
        check("reset grant_id", 32'(grant_id), 0);
        check("reset put_count", 32'(put_count), 0);
        check("reset put mb1", 32'(put1), 0);
        req = 4'b0000;
        #1 reset_n = 1'b1;
        @(posedge wclk); #1;

        for (int r = 0; r < vq.size(); r++) begin
            req      = vq[r].req;
            full_bar = vq[r].fb;
            drive_data();
            #1;
            check($sformatf("row%0d put", r), 32'(put), 32'(vq[r].put));
            check($sformatf("row%0d ack", r), 32'(ack), 32'(vq[r].ack));
            check($sformatf("row%0d grant_valid", r), 32'(grant_valid), 32'(vq[r].gv));
            check($sformatf("row%0d grant_id", r), 32'(grant_id), 32'(vq[r].gid));
            check($sformatf("row%0d put_count", r), 32'(put_count), 32'(vq[r].cnt));
            if (vq[r].put) check($sformatf("row%0d data_in", r), 32'(data_in), 32'(vq[r].data));
            for (int i = 0; i < 4; i++) if (vq[r].ack[i]) n_word[i]++;
            @(posedge wclk); #1;
        end

        // Async reset in the middle of a burst, between edges.
        req = 4'b0001;
        drive_data();
        @(posedge wclk); #1;
        check("pre-reset put", 32'(put), 1);
        check("pre-reset put_count", 32'(put_count), 22);
        #1 reset_n = 1'b0;
        #1;
        check("mid reset put", 32'(put), 0);
        check("mid reset ack", 32'(ack), 0);
        check("mid reset put_count", 32'(put_count), 0);
        check("mid reset grant_valid", 32'(grant_valid), 0);
        check("mid reset grant_id", 32'(grant_id), 0);
        for (int i = 0; i < 4; i++) n_word[i] = 0;
        req = 4'b1010;
        drive_data();
        #2 reset_n = 1'b1;
        @(posedge wclk); #1;
        check("post reset grant_id", 32'(grant_id), 1);
        check("post reset grant_valid", 32'(grant_valid), 1);
        check("post reset put", 32'(put), 1);
        check("post reset ack", 32'(ack), 32'h2);
        check("post reset data_in", 32'(data_in), 32'(wd(1, 0)));

        // MAX_BURST=1: one put per cycle rotating 0,1,2,3,0,1 and 2-bit wrap.
        req = 4'b0000;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) n_word[i] = 0;
        reset_n = 1'b1;
        req = 4'b1111;
        drive_data();
        #1;
        check("mb1 idle grant_valid", 32'(grant_valid1), 0);
        check("mb1 idle put", 32'(put1), 0);
        @(posedge wclk); #1;
        for (int k = 0; k < 6; k++) begin
            int id;
            id = k % 4;
            check($sformatf("mb1 c%0d grant_id", k), 32'(grant_id1), 32'(id));
            check($sformatf("mb1 c%0d put", k), 32'(put1), 1);
            check($sformatf("mb1 c%0d ack", k), 32'(ack1), 32'(1 << id));
            check($sformatf("mb1 c%0d data_in", k), 32'(data_in1), 32'(wd(id, n_word[id])));
            check($sformatf("mb1 c%0d put_count", k), 32'(put_count1), 32'(k % 4));
            n_word[id]++;
            drive_data();
            @(posedge wclk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
